// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and the
// load/store path, with D-side lane steering and load extension.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int unsigned RUN_W = (MAX_DATA_RUN < 1) ? 1 : $clog2(MAX_DATA_RUN + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

  state_t           state;
  logic [RUN_W-1:0] data_run;
  logic [1:0]       lat_lo;
  logic [1:0]       lat_size;
  logic             lat_unsigned;
  logic             lat_we;

  logic             run_full;
  logic             pick_d;
  logic             pick_if;
  logic             d_misaligned;
  logic [3:0]       d_be;
  logic [31:0]      d_lanes;
  logic [31:0]      load_shifted;
  logic [31:0]      load_data;
  logic [1:0]       unused_if_lo;

  assign unused_if_lo = if_addr[1:0];

  // IF wins a contested cycle only once D has used up its run allowance
  assign run_full = (MAX_DATA_RUN != 0) && (data_run == RUN_W'(MAX_DATA_RUN));
  assign pick_d   = d_req && !(if_req && run_full);
  assign pick_if  = if_req && !pick_d;

  assign d_misaligned = (d_size == 2'b11) ||
                        ((d_size == 2'b01) && d_addr[0]) ||
                        ((d_size == 2'b10) && (d_addr[1:0] != 2'b00));

  always_comb begin
    d_be    = 4'b1111;
    d_lanes = d_wdata;
    case (d_size)
      2'b00: begin
        d_be    = 4'b0001 << d_addr[1:0];
        d_lanes = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        d_be    = 4'b0011 << d_addr[1:0];
        d_lanes = {2{d_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Right-align the addressed lane of the returned word, then extend
  always_comb begin
    load_shifted = mem_rdata >> {lat_lo, 3'b000};
    load_data    = load_shifted;
    case (lat_size)
      2'b00: load_data = lat_unsigned ? {24'h0, load_shifted[7:0]}
                                      : {{24{load_shifted[7]}}, load_shifted[7:0]};
      2'b01: load_data = lat_unsigned ? {16'h0, load_shifted[15:0]}
                                      : {{16{load_shifted[15]}}, load_shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      data_run     <= '0;
      lat_lo       <= 2'b00;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_we       <= 1'b0;
      if_ack       <= 1'b0;
      if_rdata     <= '0;
      d_ack        <= 1'b0;
      d_rdata      <= '0;
      d_err        <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= 4'b0000;
      mem_wdata    <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            if (if_req) data_run <= run_full ? data_run : data_run + RUN_W'(1);
            else        data_run <= '0;
            lat_lo       <= d_addr[1:0];
            lat_size     <= d_size;
            lat_unsigned <= d_unsigned;
            lat_we       <= d_we;
            busy         <= 1'b1;
            if (d_misaligned) begin
              // Illegal access answers straight away without touching memory
              state   <= RESP;
              d_ack   <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end else begin
              state     <= BUSY_D;
              mem_req   <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
              mem_be    <= d_be;
              mem_wdata <= d_lanes;
            end
          end else if (pick_if) begin
            data_run <= '0;
            state    <= BUSY_IF;
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {if_addr[ADDR_W-1:2], 2'b00};
            mem_be   <= 4'b1111;
          end
        end
        BUSY_IF: begin
          if (mem_ready) begin
            state    <= RESP;
            mem_req  <= 1'b0;
            if_ack   <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            state   <= RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            d_ack   <= 1'b1;
            d_err   <= 1'b0;
            d_rdata <= lat_we ? 32'h0 : load_data;
          end
        end
        RESP: begin
          state  <= IDLE;
          busy   <= 1'b0;
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, stores, loads, errors, reset and fairness.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic        d_unsigned = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  logic        if_ack, d_ack, d_err, mem_req, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        s_if_ack, s_d_ack, s_d_err, s_mem_req, s_mem_we, s_busy;
  logic [31:0] s_if_rdata, s_d_rdata, s_mem_addr, s_mem_wdata;
  logic [3:0]  s_mem_be;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .MAX_DATA_RUN(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  // Strict D-priority instance sharing the same stimulus
  mem_port_arbiter #(.ADDR_W(32), .MAX_DATA_RUN(0)) u_dut_strict (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(s_if_ack), .if_rdata(s_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(s_d_ack), .d_rdata(s_d_rdata), .d_err(s_d_err),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_be(s_mem_be),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(s_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait D access: request in cycle N, memory cycle N+1, ack N+2
  task automatic d_access(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rdata);
    d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wdata;
    mem_ready = 1'b1;
    d_req = 1'b1;
    step();
    check({tag, ".mem_req"}, 32'(mem_req), 32'd1);
    check({tag, ".mem_we"}, 32'(mem_we), 32'(we));
    check({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
    check({tag, ".mem_be"}, 32'(mem_be), 32'(exp_be));
    if (we) check({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
    check({tag, ".early_ack"}, 32'(d_ack), 32'd0);
    step();
    check({tag, ".d_ack"}, 32'(d_ack), 32'd1);
    check({tag, ".d_err"}, 32'(d_err), 32'd0);
    check({tag, ".d_rdata"}, d_rdata, exp_rdata);
    check({tag, ".resp_mem_req"}, 32'(mem_req), 32'd0);
    step();
    d_req = 1'b0;
    check({tag, ".ack_pulse"}, 32'(d_ack), 32'd0);
    check({tag, ".rdata_hold"}, d_rdata, exp_rdata);
  endtask

  int order [10];
  int n_ack;
  int s_if_cnt, s_d_cnt;

  initial begin
    // Reset state
    step(); step();
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.if_ack", 32'(if_ack), 32'd0);
    check("rst.d_ack", 32'(d_ack), 32'd0);
    check("rst.mem_be", 32'(mem_be), 32'd0);
    check("rst.d_rdata", d_rdata, 32'd0);
    rst_n = 1'b1;
    step();

    // Single zero-wait fetch
    if_addr = 32'h100; mem_rdata = 32'h00A00093; mem_ready = 1'b1; if_req = 1'b1;
    step();
    check("fetch.mem_req", 32'(mem_req), 32'd1);
    check("fetch.mem_addr", mem_addr, 32'h100);
    check("fetch.mem_be", 32'(mem_be), 32'hF);
    check("fetch.mem_we", 32'(mem_we), 32'd0);
    check("fetch.busy", 32'(busy), 32'd1);
    check("fetch.early_ack", 32'(if_ack), 32'd0);
    step();
    check("fetch.if_ack", 32'(if_ack), 32'd1);
    check("fetch.if_rdata", if_rdata, 32'h00A00093);
    step();
    if_req = 1'b0;
    check("fetch.ack_pulse", 32'(if_ack), 32'd0);
    check("fetch.busy_idle", 32'(busy), 32'd0);

    // Fetch with two wait states
    if_addr = 32'h104; mem_rdata = 32'h12345678; mem_ready = 1'b0; if_req = 1'b1;
    step(); step();
    check("wait.no_ack", 32'(if_ack), 32'd0);
    check("wait.mem_req", 32'(mem_req), 32'd1);
    check("wait.addr_hold", mem_addr, 32'h104);
    mem_ready = 1'b1;
    step();
    check("wait.if_ack", 32'(if_ack), 32'd1);
    check("wait.if_rdata", if_rdata, 32'h12345678);
    step();
    if_req = 1'b0;

    // Reset in the middle of a stalled fetch
    if_addr = 32'h40; mem_ready = 1'b0; if_req = 1'b1;
    step(); step(); step();
    check("rmid.mem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmid.mem_req_drop", 32'(mem_req), 32'd0);
    check("rmid.busy", 32'(busy), 32'd0);
    check("rmid.if_rdata", if_rdata, 32'd0);
    check("rmid.mem_addr", mem_addr, 32'd0);
    check("rmid.mem_be", 32'(mem_be), 32'd0);
    #1;
    rst_n = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h11223344;
    step();
    check("rmid.regrant", 32'(mem_req), 32'd1);
    check("rmid.regrant_addr", mem_addr, 32'h40);
    step();
    check("rmid.if_ack", 32'(if_ack), 32'd1);
    check("rmid.if_rdata", if_rdata, 32'h11223344);
    step();
    if_req = 1'b0;

    // Stores and loads
    d_access("sb", 1'b1, 2'b00, 1'b0, 32'h203, 32'h000000AB, 4'b1000, 32'hABABABAB, 32'h0);
    d_access("sh", 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF, 32'h0);
    d_access("sw", 1'b1, 2'b10, 1'b0, 32'h204, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 32'h0);
    mem_rdata = 32'h80FF7F01;
    d_access("lh", 1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 4'b1100, 32'h0, 32'hFFFF80FF);
    d_access("lbu", 1'b0, 2'b00, 1'b1, 32'h1, 32'h0, 4'b0010, 32'h0, 32'h0000007F);
    d_access("lhu", 1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 4'b1100, 32'h0, 32'h000080FF);
    d_access("lw", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 4'b1111, 32'h0, 32'h80FF7F01);
    d_access("lb", 1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 4'b1000, 32'h0, 32'hFFFFFF80);

    // Misaligned word load: RESP in N+1 with no memory cycle
    d_we = 1'b0; d_size = 2'b10; d_addr = 32'h206; d_req = 1'b1;
    step();
    check("mis.mem_req", 32'(mem_req), 32'd0);
    check("mis.d_ack", 32'(d_ack), 32'd1);
    check("mis.d_err", 32'(d_err), 32'd1);
    check("mis.d_rdata", d_rdata, 32'd0);
    step();
    d_req = 1'b0;
    check("mis.ack_pulse", 32'(d_ack), 32'd0);

    // Reserved size code is always illegal
    d_size = 2'b11; d_addr = 32'h200; d_req = 1'b1;
    step();
    check("sz11.mem_req", 32'(mem_req), 32'd0);
    check("sz11.d_err", 32'(d_err), 32'd1);
    step();
    d_req = 1'b0;
    step();

    // Fairness: both requests held, acks recorded per instance
    foreach (order[i]) order[i] = 0;
    n_ack = 0; s_if_cnt = 0; s_d_cnt = 0;
    d_we = 1'b0; d_size = 2'b10; d_addr = 32'h300; if_addr = 32'h400;
    mem_ready = 1'b1; if_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step();
      if ((if_ack || d_ack) && n_ack < 10) begin
        order[n_ack] = if_ack ? 2 : 1;
        n_ack++;
      end
      if (s_if_ack) s_if_cnt++;
      if (s_d_ack) s_d_cnt++;
    end
    if_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 10; i++)
      check($sformatf("fair.order%0d", i), 32'(order[i]), (i % 5 == 4) ? 32'd2 : 32'd1);
    check("strict.if_grants", 32'(s_if_cnt), 32'd0);
    check("strict.d_grants", 32'(s_d_cnt), 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
